// File: rtl/psum_quant.sv
// Post-MAC output stage: groups N partial sums with a bias, then rounds, shifts,
// optionally applies ReLU and saturates to one signed activation per group.
module psum_quant #(
   parameter int WP = 22,
   parameter int WB = 16,
   parameter int WC = 8,
   parameter int WA = 32,
   parameter int WQ = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 vld_i,
   input  logic signed [WP-1:0] psum_i,
   input  logic        [WC-1:0] cfg_num_i,
   input  logic        [4:0]    cfg_shift_i,
   input  logic                 cfg_relu_i,
   input  logic signed [WB-1:0] bias_i,
   input  logic                 clr_i,
   output logic                 vld_o,
   output logic signed [WQ-1:0] q_o,
   output logic                 busy_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   localparam logic signed [WA:0] RND_ONE = (WA+1)'(1);
   localparam logic signed [WA:0] Q_MAX   = (WA+1)'((2 ** (WQ-1)) - 1);
   localparam logic signed [WA:0] Q_MIN   = (WA+1)'(-(2 ** (WQ-1)));

   // Group-phase state is the accepted-psum count; state is a decoded view of it.
   state_e               state;
   logic [WC-1:0]        count, count_n;
   logic [WC-1:0]        num_q, num_n, num_eff;
   logic [4:0]           shift_q, shift_n;
   logic                 relu_q, relu_n;
   logic signed [WA-1:0] acc, acc_n;
   logic signed [WA-1:0] psum_x, bias_x;
   logic                 fin, fin_n;

   logic signed [WA:0]   rnd, sum_r, shr;
   logic signed [WQ-1:0] q_n;
   logic                 emit;

   assign psum_x  = {{(WA-WP){psum_i[WP-1]}}, psum_i};
   assign bias_x  = {{(WA-WB){bias_i[WB-1]}}, bias_i};
   assign num_eff = (cfg_num_i == '0) ? WC'(1) : cfg_num_i;
   assign state   = (count == '0) ? IDLE : ACCUM;
   assign emit    = fin & ~clr_i;

   // Stage 1: group bookkeeping and accumulation.
   always_comb begin
      count_n = count;
      num_n   = num_q;
      shift_n = shift_q;
      relu_n  = relu_q;
      acc_n   = acc;
      fin_n   = 1'b0;
      if (clr_i) begin
         count_n = '0;
      end else if (vld_i) begin
         case (state)
            IDLE: begin
               num_n   = num_eff;
               shift_n = cfg_shift_i;
               relu_n  = cfg_relu_i;
               acc_n   = bias_x + psum_x;
               if (num_eff == WC'(1)) fin_n = 1'b1;
               else                   count_n = WC'(1);
            end
            ACCUM: begin
               acc_n = acc + psum_x;
               if (count + WC'(1) == num_q) begin
                  fin_n   = 1'b1;
                  count_n = '0;
               end else begin
                  count_n = count + WC'(1);
               end
            end
            default: count_n = '0;
         endcase
      end
   end

   // Stage 2: round-half-up arithmetic shift, ReLU, saturation.
   // One guard bit above WA keeps the rounding add exact for any acc.
   always_comb begin
      rnd = '0;
      if (shift_q != 5'd0) rnd = RND_ONE <<< (shift_q - 5'd1);
      sum_r = {acc[WA-1], acc} + rnd;
      shr   = sum_r >>> shift_q;
      if (relu_q && shr[WA]) shr = '0;
      if (shr > Q_MAX)      q_n = {1'b0, {(WQ-1){1'b1}}};
      else if (shr < Q_MIN) q_n = {1'b1, {(WQ-1){1'b0}}};
      else                  q_n = shr[WQ-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count   <= '0;
         num_q   <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         acc     <= '0;
         fin     <= 1'b0;
         busy_o  <= 1'b0;
         vld_o   <= 1'b0;
         q_o     <= '0;
      end else begin
         count   <= count_n;
         num_q   <= num_n;
         shift_q <= shift_n;
         relu_q  <= relu_n;
         acc     <= acc_n;
         fin     <= fin_n;
         busy_o  <= (count_n != '0);
         vld_o   <= emit;
         if (emit) q_o <= q_n;
      end
   end

endmodule

// File: doc/psum_quant.md
# psum_quant

Post-MAC output stage. Consumes the signed partial-sum stream from the 16-lane MAC adder tree and accumulates a run-time number of consecutive partial sums into one output-channel value, for example across input-channel tiles. It then adds a per-channel bias, applies a rounding arithmetic right shift, optional ReLU and signed saturation, and emits one 8-bit activation per completed group toward the output buffer.

## Interface
Parameters:
- WP, 22: partial-sum input width (signed; matches MAC accumulator output).
- WB, 16: bias width (signed).
- WC, 8: group-count width.
- WA, 32: internal accumulator width (signed).
- WQ, 8: output activation width (signed).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- vld_i  in  1  psum_i valid this cycle.
- psum_i  in  WP  signed partial sum.
- cfg_num_i  in  WC  partial sums per group; 0 is treated as 1.
- cfg_shift_i  in  5  right-shift amount, 0..31.
- cfg_relu_i  in  1  1 = clamp negatives to 0.
- bias_i  in  WB  signed bias for the group.
- clr_i  in  1  synchronous abort of the group in progress.
- vld_o  out  1  q_o valid; single-cycle pulse per group.
- q_o  out  WQ  signed quantized result.
- busy_o  out  1  group in progress (count != 0).

## Operation
- States:
  - IDLE: count == 0.
  - ACCUM: 0 < count < N.
  - Stage-2 flag `fin` marks a completed group awaiting quantization.
- Group start: vld_i in IDLE.
  - Latch N = max(cfg_num_i, 1), cfg_shift_i and cfg_relu_i.
  - acc <= sext(bias_i) + sext(psum_i).
- Config and bias inputs are ignored outside group start.
- Accumulate: vld_i in ACCUM gives acc <= acc + sext(psum_i).
- Group end: the vld_i that makes the accepted count equal N.
  - Set fin for one cycle; count returns to 0 (IDLE).
  - A new group may start on the very next cycle.
- A vld_i gap pauses accumulation; nothing is lost.
- Overflow: with WA=32, WP=22 and N <= 255, acc cannot overflow; no wrap handling is required.
- Quantize stage, registered, with s = latched shift:
  - s = 0: r = acc.
  - s > 0: r = (acc + 2^(s-1)) >>> s, i.e. round-half-up, arithmetic.
  - If relu: r = max(r, 0).
  - Saturate to [-2^(WQ-1), 2^(WQ-1)-1] = [-128, 127].
  - q_o <= result; vld_o <= 1.
- q_o holds its last value when vld_o = 0.
- clr_i:
  - Clears count and fin; the in-flight group is discarded and does not produce vld_o.
  - clr_i with vld_i in the same cycle: clr wins and psum_i is dropped.
  - clr_i does not cancel a vld_o already registered.
- No backpressure: the consumer must accept every vld_o pulse.

## Timing
- Reset values: vld_o = 0, q_o = 0, busy_o = 0, count = 0, fin = 0, acc = 0, latched cfg = 0.
- Reset asserted mid-group: the group is lost and all state takes the reset values immediately (asynchronous).
- Latency: final vld_i sampled at edge k gives fin at edge k; q_o/vld_o are registered at edge k+1. vld_o is therefore high in the cycle two edges after the final psum is presented.
- Throughput: one psum per cycle. With N = 1 and continuous vld_i, vld_o is high every cycle after 2 cycles of fill.
- busy_o is registered: it is high the cycle after group start and low the cycle after group end.

## Test plan
- N=1, bias=0, shift=0, relu=0; psum=5 -> q_o=5, vld_o one pulse 2 cycles after input; busy_o stays 0.
- N=4, bias=24, shift=4; psums 100, 200, 300, 400 back-to-back -> acc=1024, q_o=(1024+8)>>>4=64. Repeat with a 3-cycle vld_i gap after the 2nd psum -> same 64, vld_o delayed by 3 cycles.
- Rounding/sign, N=1, shift=4, bias=0:
  - psum=-24 -> -1 (0xFF).
  - psum=-25 -> -2 (0xFE).
  - psum=23 -> 1.
  - psum=24 -> 2.
- Saturation/ReLU, N=1, shift=0:
  - psum=100000 -> 127.
  - psum=-100000 -> -128 (0x80).
  - psum=-100000 with relu=1 -> 0.
  - cfg_num_i=0 behaves as N=1.
- Streaming, N=2, 6 consecutive psums 1..6, bias=0, shift=0 -> q_o = 3, 7, 11 on vld_o pulses at cycles 3, 5, 7 after the first psum. Changing cfg_num_i mid-group has no effect until the next group start.
- Abort/reset:
  - N=4, clr_i with the 3rd psum -> no vld_o; the next group of 4 ones with bias=0 -> q_o=4.
  - rstn low mid-group -> all outputs 0 immediately; the following group is correct.
